pipelined_sum_sub: RTL and testbench
====================================

Name: pipelined_sum_sub

Overview:
- Parametrised, pipelined add/subtract/compare unit for the RISC-V datapath; successor to the single-cycle ripple adder-subtractor.
- Splits the WIDTH-bit carry chain into STAGES registered slices to shorten the critical path.
- Adds SLT/SLTU modes, NZCV flags, a sideband tag and valid/ready handshaking on both sides.
- Sits between the operand-select stage and writeback/branch-resolve logic.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; carry-chain slice width is WIDTH/STAGES; legal range 1..WIDTH.
- TAG_W, 5, sideband tag width (e.g. destination register index), carried unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands/op/tag valid this cycle.
- in_ready  output  1  unit accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  ADD/SUB: sum; SLT/SLTU: zero-extended 1-bit compare.
- flag_n  output  1  sum[WIDTH-1].
- flag_z  output  1  sum == 0.
- flag_c  output  1  carry-out of the full-width adder; for SUB/SLT/SLTU, 1 means no borrow (a >= b unsigned).
- flag_v  output  1  signed overflow of the sum.
- out_tag  output  TAG_W  tag accepted with this result.

Behaviour:
- Reset is synchronous and active-low: when rst_n is low at a rising clk edge, all stage valid bits, data registers, outputs and out_tag clear to 0. in_ready is 1 from the first cycle after reset. Reset mid-operation discards all in-flight items; nothing is emitted for them.
- Internal operation: SUB, SLT and SLTU compute a + ~b + 1 (carry-in = 1, b inverted). ADD computes a + b (carry-in = 0).
- Stage k (0..STAGES-1) adds bits [k*S +: S], with S = WIDTH/STAGES, using the carry registered from stage k-1. Stage 0 uses the op carry-in.
- Operand skew: slice k operands are delayed k cycles so they meet their carry. Completed lower sum slices are delayed so all slices align at the output.
- Final stage also produces the outputs:
  - flags: N = sum msb; Z = (sum == 0); C = carry-out; V = (a_msb == b'_msb) and (sum_msb != a_msb), where b' is the inverted b for SUB/SLT/SLTU.
  - result: SLT -> {0, N^V}; SLTU -> {0, ~C}; ADD/SUB -> sum.
- Latency: exactly STAGES cycles from the accepting edge (in_valid & in_ready) to out_valid, when unstalled. Throughput: 1 per cycle.
- Handshake uses a global advance enable: advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 0, every stage register (including skew registers, valids and tag) holds.
  - Bubbles are not collapsed.
  - result, flags and out_tag are stable while out_valid & !out_ready.
- No combinational path from in_valid or a/b to out_* outputs. in_ready depends combinationally only on out_ready and registered state.
- in_valid low at an advancing edge inserts a bubble (stage valid = 0). Data in bubble slots is don't-care, but the registers still advance.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- STAGES = 1: a single registered full-width add with latency 1.
- Wrap-around: ADD/SUB are modulo 2^WIDTH; overflow is reported only via flag_v/flag_c.

Decomposition:
- Package pipelined_sum_sub_pkg holds:
  - op encodings as localparams: OP_ADD, OP_SUB, OP_SLT, OP_SLTU.
  - a helper function that returns the op carry-in / invert-b bit.
  - the flag-vector bit positions N, Z, C, V.
- One sub-module, sum_sub_slice: a parametrised S-bit registered adder slice with carry-in, carry-out and enable. It is instantiated STAGES times by a generate loop. Skew and alignment registers live in the top level.

Test Plan:
- ADD: a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=00 -> after 4 cycles result=0x8000_0000_0000_0000, N=1, Z=0, C=0, V=1.
- SUB carry across a slice boundary: a=0x0000_0000_0001_0000, b=1, op=01 -> result=0x0000_0000_0000_FFFF, C=1, V=0, Z=0. a=b=0x1234 -> result=0, Z=1, C=1.
- SLT vs SLTU: a=0xFFFF_FFFF_FFFF_FFFF (-1), b=1 -> SLT result=1; SLTU result=0, C=1.
- Back-to-back stream of 8 ADDs (tags 0..7) with out_ready held 1 -> one result per cycle, in order, tags 0..7, first result at cycle 4.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready=0 for those cycles, outputs held stable, no loss or duplication, order preserved.
- Reset mid-stream: rst_n=0 for one edge with 3 items in flight -> out_valid=0 and outputs 0 the next cycle; the in-flight items are never emitted; a new ADD 2+3 then gives result=5 after 4 cycles.

Source files
------------

// File: rtl/pipelined_sum_sub_pkg.sv
// Shared op encodings, flag-vector layout and carry-in helper for the
// pipelined add/subtract/compare unit.
package pipelined_sum_sub_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  localparam int FLAG_W = 4;

  // Every op except ADD is a subtraction: invert b and carry in a 1.
  function automatic logic op_cin(input logic [1:0] op);
    return (op != OP_ADD);
  endfunction

endpackage

// File: rtl/sum_sub_slice.sv
// One registered S-bit slice of the carry chain; sum and carry-out are
// captured together when enabled.
module sum_sub_slice #(
  parameter int S = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [S-1:0] a_i,
  input  logic [S-1:0] b_i,
  input  logic         cin_i,
  output logic [S-1:0] sum_o,
  output logic         cout_o
);

  logic [S:0]   sum_d;
  logic [S-1:0] sum_q;
  logic         cout_q;

  assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{S{1'b0}}, cin_i};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en_i) begin
      {cout_q, sum_q} <= sum_d;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: rtl/pipelined_sum_sub.sv
// Pipelined ADD/SUB/SLT/SLTU unit: the carry chain is cut into STAGES
// registered slices, with operand skew and result alignment held here.
module pipelined_sum_sub
  import pipelined_sum_sub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S    = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  function automatic logic [WIDTH-1:0] place(input logic [S-1:0] s, input int k);
    logic [WIDTH-1:0] r;
    r          = '0;
    r[k*S +: S] = s;
    return r;
  endfunction

  logic                    advance;
  logic                    cin_in;
  logic [WIDTH-1:0]        bx_in;

  logic [STAGES-1:0]       vld_q;
  logic [WIDTH-1:0]        a_q   [STAGES];
  logic [WIDTH-1:0]        bx_q  [STAGES];
  logic [WIDTH-1:0]        lo_q  [STAGES];
  logic [1:0]              op_q  [STAGES];
  logic [TAG_W-1:0]        tag_q [STAGES];

  logic [STAGES-1:0][S-1:0] sl_sum;
  logic [STAGES-1:0]        sl_cout;

  // A single global enable: the whole pipe moves or the whole pipe holds.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign cin_in = op_cin(op);
  assign bx_in  = cin_in ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    if (k == 0) begin : g_first
      sum_sub_slice #(.S(S)) u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (advance),
        .a_i    (a[0 +: S]),
        .b_i    (bx_in[0 +: S]),
        .cin_i  (cin_in),
        .sum_o  (sl_sum[k]),
        .cout_o (sl_cout[k])
      );
    end else begin : g_rest
      sum_sub_slice #(.S(S)) u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (advance),
        .a_i    (a_q[k-1][k*S +: S]),
        .b_i    (bx_q[k-1][k*S +: S]),
        .cin_i  (sl_cout[k-1]),
        .sum_o  (sl_sum[k]),
        .cout_o (sl_cout[k])
      );
    end
  end

  // Stage boundaries: operands skew forward, finished lower slices align.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        bx_q[k]  <= '0;
        lo_q[k]  <= '0;
        op_q[k]  <= '0;
        tag_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      bx_q[0]  <= bx_in;
      lo_q[0]  <= '0;
      op_q[0]  <= op;
      tag_q[0] <= in_tag;
      for (int k = 1; k < STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        bx_q[k]  <= bx_q[k-1];
        lo_q[k]  <= lo_q[k-1] | place(sl_sum[k-1], k-1);
        op_q[k]  <= op_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  logic [WIDTH-1:0]  sum_full;
  logic [FLAG_W-1:0] flags;
  logic [WIDTH-1:0]  res_sel;

  always_comb begin
    sum_full       = lo_q[LAST] | place(sl_sum[LAST], LAST);
    flags          = '0;
    flags[FLAG_N]  = sum_full[WIDTH-1];
    flags[FLAG_Z]  = (sum_full == '0);
    flags[FLAG_C]  = sl_cout[LAST];
    flags[FLAG_V]  = (a_q[LAST][WIDTH-1] == bx_q[LAST][WIDTH-1]) &&
                     (sum_full[WIDTH-1] != a_q[LAST][WIDTH-1]);
    res_sel        = sum_full;
    case (op_q[LAST])
      OP_SLT:  res_sel = {{(WIDTH-1){1'b0}}, flags[FLAG_N] ^ flags[FLAG_V]};
      OP_SLTU: res_sel = {{(WIDTH-1){1'b0}}, ~flags[FLAG_C]};
      default: res_sel = sum_full;
    endcase
  end

  // Outputs read as zero whenever no result is presented.
  assign out_valid = vld_q[LAST];
  assign result    = out_valid ? res_sel : '0;
  assign flag_n    = out_valid & flags[FLAG_N];
  assign flag_z    = out_valid & flags[FLAG_Z];
  assign flag_c    = out_valid & flags[FLAG_C];
  assign flag_v    = out_valid & flags[FLAG_V];
  assign out_tag   = out_valid ? tag_q[LAST] : '0;

endmodule

// File: tb/tb_pipelined_sum_sub.sv
// Scoreboard bench for pipelined_sum_sub: expectations are queued at the
// accepting edge and compared when results are presented.
module tb_pipelined_sum_sub;
  import pipelined_sum_sub_pkg::*;

  localparam int WIDTH  = 64;
  localparam int STAGES = 4;
  localparam int TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic [1:0]       op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n, flag_z, flag_c, flag_v;
  logic [TAG_W-1:0] out_tag;

  pipelined_sum_sub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic [3:0]       flg;
    logic [TAG_W-1:0] tag;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   lat_on;
  bit   rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] mkf(input logic n, input logic z, input logic c, input logic v);
    logic [3:0] f;
    f = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // Reference model written from the arithmetic meaning of each op.
  task automatic model(input logic [63:0] ta, input logic [63:0] tb_, input logic [1:0] top,
                       output logic [63:0] res, output logic [3:0] flg);
    logic [64:0]        s65;
    logic signed [65:0] sx;
    logic [63:0]        sum;
    logic               c, v;
    if (top == OP_ADD) begin
      s65 = {1'b0, ta} + {1'b0, tb_};
      sum = s65[63:0];
      c   = s65[64];
      sx  = $signed({ta[63], ta[63], ta}) + $signed({tb_[63], tb_[63], tb_});
    end else begin
      sum = ta - tb_;
      c   = (ta >= tb_);
      sx  = $signed({ta[63], ta[63], ta}) - $signed({tb_[63], tb_[63], tb_});
    end
    v = !(sx[65:63] == 3'b000 || sx[65:63] == 3'b111);
    case (top)
      OP_SLT:  res = {63'd0, ($signed(ta) < $signed(tb_))};
      OP_SLTU: res = {63'd0, (ta < tb_)};
      default: res = sum;
    endcase
    flg = mkf(sum[63], sum == 64'd0, c, v);
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send_x(input logic [63:0] ta, input logic [63:0] tb_, input logic [1:0] top,
                        input logic [TAG_W-1:0] ttag, input logic [63:0] er, input logic [3:0] ef);
    int   n;
    exp_t e;
    n = 0;
    a = ta; b = tb_; op = top; in_tag = ttag; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      e.res = er; e.flg = ef; e.tag = ttag; e.acc = cyc; e.lat = lat_on;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] ta, input logic [63:0] tb_, input logic [1:0] top,
                      input logic [TAG_W-1:0] ttag);
    logic [63:0] r;
    logic [3:0]  f;
    model(ta, tb_, top, r, f);
    send_x(ta, tb_, top, ttag, r, f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Output monitor: compare the head on every presented cycle, pop on transfer.
  always @(negedge clk) begin
    exp_t       e;
    logic [3:0] fv;
    if (!rst_n) begin
      sb.delete();
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 64'd1, 64'd0);
      end else begin
        e  = sb[0];
        fv = mkf(flag_n, flag_z, flag_c, flag_v);
        chk("result", result, e.res);
        chk("flags", 64'(fv), 64'(e.flg));
        chk("tag", 64'(out_tag), 64'(e.tag));
        if (out_ready) begin
          chk("in_ready_flow", 64'(in_ready), 64'd1);
          if (e.lat) chk("latency", 64'(cyc - e.acc), 64'(STAGES));
          void'(sb.pop_front());
        end else begin
          chk("in_ready_stall", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = OP_ADD; in_tag = '0;
    out_ready = 1'b1; lat_on = 1'b1; rnd_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'(mkf(flag_n, flag_z, flag_c, flag_v)), 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived expectations.
    send_x(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 5'd1,
           64'h8000_0000_0000_0000, mkf(1'b1, 1'b0, 1'b0, 1'b1));
    send_x(64'h0000_0000_0001_0000, 64'd1, OP_SUB, 5'd2,
           64'h0000_0000_0000_FFFF, mkf(1'b0, 1'b0, 1'b1, 1'b0));
    send_x(64'h1234, 64'h1234, OP_SUB, 5'd3,
           64'd0, mkf(1'b0, 1'b1, 1'b1, 1'b0));
    send_x(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_SLT, 5'd4,
           64'd1, mkf(1'b1, 1'b0, 1'b1, 1'b0));
    send_x(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OP_SLTU, 5'd5,
           64'd0, mkf(1'b1, 1'b0, 1'b1, 1'b0));
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, OP_ADD, 5'd6);
    send(64'h8000_0000_0000_0000, 64'd1, OP_SUB, 5'd7);
    drain();

    // Back-to-back stream, tags 0..7.
    for (int i = 0; i < 8; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, OP_ADD, 5'(i));
    drain();

    // Backpressure for 3 cycles mid-stream.
    lat_on = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send({$urandom, $urandom}, {$urandom, $urandom}, 2'(i), 5'(8 + i));
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random ops under random backpressure.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          logic [63:0] ra, rb;
          ra = {$urandom, $urandom};
          rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
          send(ra, rb, 2'($urandom_range(0, 3)), 5'($urandom));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three items in flight: none of them may appear.
    lat_on = 1'b1;
    send(64'd10, 64'd20, OP_ADD, 5'd21);
    send(64'd30, 64'd40, OP_SUB, 5'd22);
    send(64'd50, 64'd60, OP_ADD, 5'd23);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    send_x(64'd2, 64'd3, OP_ADD, 5'd9, 64'd5, mkf(1'b0, 1'b0, 1'b0, 1'b0));
    drain();
    repeat (6) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
